// File: rtl/multimode_counter_param.sv
// multimode_counter_param
//   WIDTH-bit modulo counter with up / down / bounce / hold modes,
//   synchronous clear and load, a programmable prescaler and a
//   registered terminal-count pulse with a sticky overflow flag.
//
//   Optional feature: define MMC_GRAY_EN to add the combinational
//   count_gray output (Gray code of the count register).
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   ena        : global enable; 0 freezes all state, clear/load ignored
//   mode       : 00 up, 01 down, 10 bounce, 11 hold
//   clear      : synchronous clear (highest priority)
//   load       : synchronous load of load_val
//   load_val   : load value, not clamped to limit
//   limit      : maximum count (modulus - 1)
//   prescale   : step once every prescale+1 enabled cycles
//   count      : current count (registered)
//   tc         : terminal-count pulse (registered)
//   dir        : current direction, 1 = up (registered)
//   ovf        : sticky overflow, set with tc (registered)
//   count_gray : Gray-coded count (MMC_GRAY_EN only, combinational)
module multimode_counter_param #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  dir,
    output logic                  ovf
`ifdef MMC_GRAY_EN
    ,
    output logic [WIDTH-1:0]      count_gray
`endif
);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] presc_nxt;
    logic [WIDTH-1:0]      count_nxt;
    logic                  tc_nxt;
    logic                  dir_nxt;
    logic                  ovf_nxt;
    logic                  wrap;

    // Next-state: clear > load > prescaled step; everything frozen when !ena
    always_comb begin
        count_nxt = count;
        presc_nxt = presc;
        tc_nxt    = tc;
        dir_nxt   = dir;
        ovf_nxt   = ovf;
        wrap      = 1'b0;

        if (ena) begin
            tc_nxt = 1'b0;
            if (clear) begin
                count_nxt = '0;
                presc_nxt = '0;
                dir_nxt   = 1'b1;
                ovf_nxt   = 1'b0;
            end else if (load) begin
                count_nxt = load_val;
                presc_nxt = '0;
            end else if (mode != MODE_HOLD) begin
                if (presc == prescale) begin
                    presc_nxt = '0;
                    case (mode)
                        MODE_UP: begin
                            dir_nxt = 1'b1;
                            // >= so a loaded value above limit wraps at once
                            if (count >= limit) begin
                                count_nxt = '0;
                                wrap      = 1'b1;
                            end else begin
                                count_nxt = count + WIDTH'(1);
                            end
                        end
                        MODE_DOWN: begin
                            dir_nxt = 1'b0;
                            if (count == '0) begin
                                count_nxt = limit;
                                wrap      = 1'b1;
                            end else begin
                                count_nxt = count - WIDTH'(1);
                            end
                        end
                        default: begin
                            // Bounce; limit==0 pins the count and just flips dir
                            if (limit == '0) begin
                                count_nxt = '0;
                                dir_nxt   = ~dir;
                                wrap      = 1'b1;
                            end else if (dir && (count >= limit)) begin
                                count_nxt = limit - WIDTH'(1);
                                dir_nxt   = 1'b0;
                                wrap      = 1'b1;
                            end else if (!dir && (count == '0)) begin
                                count_nxt = WIDTH'(1);
                                dir_nxt   = 1'b1;
                                wrap      = 1'b1;
                            end else if (dir) begin
                                count_nxt = count + WIDTH'(1);
                            end else begin
                                count_nxt = count - WIDTH'(1);
                            end
                        end
                    endcase
                end else begin
                    presc_nxt = presc + PRESCALE_W'(1);
                end
            end

            if (wrap) begin
                tc_nxt  = 1'b1;
                ovf_nxt = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            presc <= '0;
            tc    <= 1'b0;
            dir   <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            presc <= presc_nxt;
            tc    <= tc_nxt;
            dir   <= dir_nxt;
            ovf   <= ovf_nxt;
        end
    end

`ifdef MMC_GRAY_EN
    // Gray view of the registered count
    assign count_gray = count ^ (count >> 1);
`endif

endmodule

// File: tb/tb_multimode_counter_param.sv
// Directed self-checking bench for multimode_counter_param (WIDTH=8,
// PRESCALE_W=4). Inputs change 1 time unit after the rising edge and
// outputs are sampled there too, away from the active edge.
module tb_multimode_counter_param;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned PRESCALE_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  ena;
    logic [1:0]            mode;
    logic                  clear;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  dir;
    logic                  ovf;
`ifdef MMC_GRAY_EN
    logic [WIDTH-1:0]      count_gray;
`endif

    int errors = 0;
    int checks = 0;

    multimode_counter_param #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mode       (mode),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .limit      (limit),
        .prescale   (prescale),
        .count      (count),
        .tc         (tc),
        .dir        (dir),
        .ovf        (ovf)
`ifdef MMC_GRAY_EN
        ,
        .count_gray (count_gray)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int t, input int d, input int o);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".dir"},   32'(dir),   32'(d));
        chk({tag, ".ovf"},   32'(ovf),   32'(o));
    endtask

    initial begin
        int exp_b_cnt [7] = '{1, 2, 3, 2, 1, 0, 1};
        int exp_b_tc  [7] = '{0, 0, 0, 1, 0, 0, 1};
        int exp_b_dir [7] = '{1, 1, 1, 0, 0, 0, 1};

        rst_n = 1'b0; ena = 1'b0; mode = 2'b00; clear = 1'b0; load = 1'b0;
        load_val = '0; limit = 8'd5; prescale = '0;
        cycle(); cycle();
        chk_all("reset", 0, 0, 1, 0);
        rst_n = 1'b1;

        // Disabled: nothing moves
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk_all("ena_low", 0, 0, 1, 0);
        end

        // Up wrap with limit 5, prescale 0
        ena = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("up.count", 32'(count), 32'(i % 6));
            chk("up.tc",    32'(tc),    32'(i == 6));
        end
        chk("up.ovf", 32'(ovf), 32'd1);
        cycle();
        chk("up.after_wrap.count", 32'(count), 32'd1);
        chk("up.after_wrap.tc",    32'(tc),    32'd0);

        // Prescale 2: each value held three cycles
        prescale = 4'd2;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("presc2.count", 32'(count), 32'(1 + i / 3));
        end

        // Down from loaded 200 (above limit), wrapping to limit
        prescale = '0; mode = 2'b01; load_val = 8'd200; load = 1'b1;
        cycle();
        chk_all("load200", 200, 0, 1, 1);
        load = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            chk("down.count", 32'(count), 32'(200 - i));
            chk("down.tc",    32'(tc),    32'd0);
        end
        chk("down.dir", 32'(dir), 32'd0);
        cycle();
        chk("down.wrap.count", 32'(count), 32'd5);
        chk("down.wrap.tc",    32'(tc),    32'd1);
        cycle();
        chk("down.after.count", 32'(count), 32'd4);
        chk("down.after.tc",    32'(tc),    32'd0);

        // Clear beats load
        load = 1'b1; clear = 1'b1;
        cycle();
        chk_all("clear_load", 0, 0, 1, 0);
        load = 1'b0; clear = 1'b0;

        // Bounce limit 3
        mode = 2'b10; limit = 8'd3;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("bounce3.count", 32'(count), 32'(exp_b_cnt[i]));
            chk("bounce3.tc",    32'(tc),    32'(exp_b_tc[i]));
            chk("bounce3.dir",   32'(dir),   32'(exp_b_dir[i]));
        end

        // Bounce limit 0: count pinned at 0, dir toggles, tc every step
        limit = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bounce0.count", 32'(count), 32'd0);
            chk("bounce0.tc",    32'(tc),    32'd1);
            chk("bounce0.dir",   32'(dir),   32'(i % 2));
        end

        // Hold mid-prescale freezes the prescaler phase
        clear = 1'b1;
        cycle();
        clear = 1'b0; mode = 2'b00; limit = 8'd5; prescale = 4'd3;
        cycle(); cycle();
        mode = 2'b11;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold.count", 32'(count), 32'd0);
            chk("hold.tc",    32'(tc),    32'd0);
        end
        mode = 2'b00;
        cycle();
        chk("resume1.count", 32'(count), 32'd0);
        cycle();
        chk("resume2.count", 32'(count), 32'd1);

        // Enable low ignores clear
        ena = 1'b0; clear = 1'b1;
        cycle();
        chk("ena_low_clear.count", 32'(count), 32'd1);
        ena = 1'b1; clear = 1'b0;

        // Up mode with a loaded value above limit wraps immediately
        prescale = '0; load_val = 8'd200; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk("up_above_limit.count", 32'(count), 32'd0);
        chk("up_above_limit.tc",    32'(tc),    32'd1);

        // Full-range counter
        clear = 1'b1;
        cycle();
        clear = 1'b0; limit = 8'd255;
        for (int i = 1; i <= 255; i++) begin
            cycle();
            chk("full.count", 32'(count), 32'(i));
        end
        chk("full.tc_before", 32'(tc), 32'd0);
        cycle();
        chk("full.wrap.count", 32'(count), 32'd0);
        chk("full.wrap.tc",    32'(tc),    32'd1);

        // Down from 0 with limit 255, then async reset mid-cycle
        mode = 2'b01;
        cycle();
        chk_all("down_full", 255, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 1, 0);
        cycle();
        rst_n = 1'b1; mode = 2'b00; prescale = 4'd2; limit = 8'd5;
        cycle(); cycle();
        chk("post_reset.count_early", 32'(count), 32'd0);
        cycle();
        chk("post_reset.count_step", 32'(count), 32'd1);

`ifdef MMC_GRAY_EN
        load_val = 8'd6; load = 1'b1;
        cycle();
        load = 1'b0;
        chk("gray6", 32'(count_gray), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
